// File: rtl/melody_pkg.sv
// Shared types for the melody sequencer: score entry layout, note codes and FSM states.
package melody_pkg;

    localparam int unsigned ENTRY_W  = 16;
    localparam int unsigned FIELD_W  = 4;
    localparam int unsigned DUR_W    = 8;
    localparam int unsigned NOTE_LSB = 12;
    localparam int unsigned OCT_LSB  = 8;
    localparam int unsigned DUR_LSB  = 0;

    localparam logic [FIELD_W-1:0] NOTE_C    = 4'd0;
    localparam logic [FIELD_W-1:0] NOTE_CS   = 4'd1;
    localparam logic [FIELD_W-1:0] NOTE_D    = 4'd2;
    localparam logic [FIELD_W-1:0] NOTE_DS   = 4'd3;
    localparam logic [FIELD_W-1:0] NOTE_E    = 4'd4;
    localparam logic [FIELD_W-1:0] NOTE_F    = 4'd5;
    localparam logic [FIELD_W-1:0] NOTE_FS   = 4'd6;
    localparam logic [FIELD_W-1:0] NOTE_G    = 4'd7;
    localparam logic [FIELD_W-1:0] NOTE_GS   = 4'd8;
    localparam logic [FIELD_W-1:0] NOTE_A    = 4'd9;
    localparam logic [FIELD_W-1:0] NOTE_AS   = 4'd10;
    localparam logic [FIELD_W-1:0] NOTE_B    = 4'd11;
    localparam logic [FIELD_W-1:0] NOTE_REST = 4'd15;

    localparam logic [DUR_W-1:0] END_DUR = 8'd0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        PLAY,
        GAP,
        ADVANCE
    } state_e;

    typedef struct packed {
        logic [FIELD_W-1:0] note;
        logic [FIELD_W-1:0] octave;
        logic [DUR_W-1:0]   dur;
    } entry_t;

    function automatic entry_t decode_entry(input logic [ENTRY_W-1:0] raw);
        entry_t e;
        e.note   = raw[NOTE_LSB +: FIELD_W];
        e.octave = raw[OCT_LSB +: FIELD_W];
        e.dur    = raw[DUR_LSB +: DUR_W];
        return e;
    endfunction

    // Codes above B (12..14) and the explicit rest code all play silently.
    function automatic logic is_rest(input logic [FIELD_W-1:0] n);
        return (n > NOTE_B) || (n == NOTE_REST);
    endfunction

endpackage

// File: rtl/melody_sequencer_tick_timer.sv
// Free-running cycle counter that pulses tick on the last cycle of each PERIOD while enabled.
module tick_timer #(
    parameter int unsigned PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = (PERIOD > 1) ? CNT_W'(PERIOD - 1) : '0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/melody_sequencer.sv
// Steps through an external score ROM and drives note/octave/mute for the pitch generator.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 6_250_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic                loop,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [ENTRY_W-1:0]  rom_data,
    output logic [FIELD_W-1:0]  note,
    output logic [FIELD_W-1:0]  octave,
    output logic                mute,
    output logic                busy,
    output logic                done
);

    state_e              state_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic [FIELD_W-1:0]  note_q;
    logic [FIELD_W-1:0]  octave_q;
    logic [DUR_W-1:0]    dur_q;
    logic                mute_q;
    logic                busy_q;
    logic                done_q;

    entry_t entry_c;
    logic   play_en_c;
    logic   play_clr_c;
    logic   play_tick_c;
    logic   gap_en_c;
    logic   gap_clr_c;
    logic   gap_tick_c;
    logic   end_c;

    assign entry_c    = decode_entry(rom_data);
    assign play_en_c  = (state_q == PLAY) && !pause;
    assign play_clr_c = (state_q != PLAY);
    assign gap_en_c   = (state_q == GAP) && !pause;
    assign gap_clr_c  = (state_q != GAP);

    // End of score: explicit end marker, or stepping past the last ROM address.
    assign end_c = ((state_q == DECODE) && (entry_c.dur == END_DUR)) ||
                   ((state_q == ADVANCE) && (rom_addr_q == {ADDR_W{1'b1}}));

    tick_timer #(.PERIOD(TICK_CYCLES)) u_dur_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (play_en_c),
        .clr  (play_clr_c),
        .tick (play_tick_c)
    );

    tick_timer #(.PERIOD(GAP_CYCLES)) u_gap_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (gap_en_c),
        .clr  (gap_clr_c),
        .tick (gap_tick_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            note_q     <= '0;
            octave_q   <= '0;
            dur_q      <= '0;
            mute_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q    <= IDLE;
                rom_addr_q <= '0;
                mute_q     <= 1'b1;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= FETCH;
                            busy_q  <= 1'b1;
                        end
                    end
                    FETCH: state_q <= DECODE;
                    DECODE: begin
                        if (!end_c) begin
                            note_q   <= entry_c.note;
                            octave_q <= entry_c.octave;
                            dur_q    <= entry_c.dur;
                            mute_q   <= is_rest(entry_c.note);
                            state_q  <= PLAY;
                        end
                    end
                    PLAY: begin
                        mute_q <= pause || is_rest(note_q);
                        if (play_tick_c) begin
                            if (dur_q == DUR_W'(1)) begin
                                mute_q  <= 1'b1;
                                state_q <= (GAP_CYCLES == 0) ? ADVANCE : GAP;
                            end else begin
                                dur_q <= dur_q - DUR_W'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (gap_tick_c) begin
                            state_q <= ADVANCE;
                        end
                    end
                    ADVANCE: begin
                        if (!end_c) begin
                            rom_addr_q <= rom_addr_q + ADDR_W'(1);
                            state_q    <= FETCH;
                        end
                    end
                    default: state_q <= IDLE;
                endcase

                // Looping restarts silently; otherwise finish with a single done pulse.
                if (end_c) begin
                    rom_addr_q <= '0;
                    if (loop) begin
                        state_q <= FETCH;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign rom_addr = rom_addr_q;
    assign note     = note_q;
    assign octave   = octave_q;
    assign mute     = mute_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
